// File: rtl/edge_arb_pkg.sv
// -----------------------------------------------------------------------------
// edge_arb_pkg
//   Shared definitions for the edge-event arbiter:
//     - per-channel edge-select codes (MODE_*)
//     - presenter FSM state encoding (ST_IDLE / ST_PRESENT)
// -----------------------------------------------------------------------------
package edge_arb_pkg;

  // Per-channel edge select, two bits per channel
  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Presenter FSM: either nothing on the bus, or one event held until accepted
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/edge_det_ch.sv
// -----------------------------------------------------------------------------
// edge_det_ch
//   One channel of the edge-event arbiter: registers the input, detects the
//   selected edge, and keeps a pending flag plus a sticky overflow flag.
//   With EDGE_ARB_STAMP_EN defined it also captures the timestamp of the
//   pending event.
//
// Ports
//   clk        system clock
//   n_rst      synchronous active-low reset
//   in         channel input (already synchronous to clk)
//   mode       edge select (MODE_OFF/RISE/FALL/BOTH)
//   accept     this channel's event is being consumed this cycle
//   ovf_clr    clear pulse for the overflow flag
//   stamp_now  current timestamp        (EDGE_ARB_STAMP_EN only)
//   stamp      timestamp of pending evt (EDGE_ARB_STAMP_EN only)
//   in_reg     registered copy of in
//   pend       event pending
//   ovf        sticky overflow: an edge arrived while an event was still pending
// -----------------------------------------------------------------------------
module edge_det_ch
  import edge_arb_pkg::*;
`ifdef EDGE_ARB_STAMP_EN
#(
  parameter int STAMP_W = 16
)
`endif
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic               in,
  input  logic [1:0]         mode,
  input  logic               accept,
  input  logic               ovf_clr,
`ifdef EDGE_ARB_STAMP_EN
  input  logic [STAMP_W-1:0] stamp_now,
  output logic [STAMP_W-1:0] stamp,
`endif
  output logic               in_reg,
  output logic               pend,
  output logic               ovf
);

  logic rise;
  logic fall;
  logic det;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rise = in & ~in_reg;
    fall = ~in & in_reg;
    det  = 1'b0;
    case (mode)
      MODE_RISE: det = rise;
      MODE_FALL: det = fall;
      MODE_BOTH: det = rise | fall;
      default:   det = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      in_reg <= 1'b0;
      pend   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      in_reg <= in;
      // A new edge on the cycle of acceptance becomes the next pending event.
      if (det)         pend <= 1'b1;
      else if (accept) pend <= 1'b0;
      // Overflow only when an edge lands on an event that is not being drained;
      // setting wins over a simultaneous clear.
      if (det && pend && !accept) ovf <= 1'b1;
      else if (ovf_clr)           ovf <= 1'b0;
    end
  end

`ifdef EDGE_ARB_STAMP_EN
  // Capture only when a fresh event becomes pending; an overflowing edge keeps
  // the time of the original event.
  always_ff @(posedge clk) begin
    if (!n_rst)                    stamp <= '0;
    else if (det && (!pend || accept)) stamp <= stamp_now;
  end
`endif

endmodule

// File: rtl/edge_evt_arbiter.sv
// -----------------------------------------------------------------------------
// edge_evt_arbiter
//   Multi-channel edge-event scheduler. Each channel detects a programmable
//   edge and latches a pending event; pending events are served one at a time
//   over a valid/ready handshake in round-robin order, back-to-back with no
//   bubble while more events are pending.
//
//   Optional feature macro: EDGE_ARB_STAMP_EN
//     defined   -> free-running STAMP_W-bit counter, per-channel capture, and
//                  the evt_stamp output port
//     undefined -> no counter, no stamp registers, no evt_stamp port
//
// Ports
//   clk        system clock (rising edge)
//   n_rst      synchronous active-low reset
//   in         N channel inputs, synchronous to clk
//   mode       per-channel edge select, ch i = mode[2i+1:2i]
//   ovf_clr    per-channel overflow clear pulse
//   evt_ready  consumer accepts the presented event
//   in_reg     registered copy of in
//   pend       pending-event flags
//   ovf        sticky overflow flags
//   evt_valid  an event is presented
//   evt_id     channel number of the presented event
//   evt_stamp  capture time of the presented event (EDGE_ARB_STAMP_EN only)
// -----------------------------------------------------------------------------
module edge_evt_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int STAMP_W = 16,
  localparam int IDW    = $clog2(N)
)
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic [N-1:0]       in,
  input  logic [2*N-1:0]     mode,
  input  logic [N-1:0]       ovf_clr,
  input  logic               evt_ready,
  output logic [N-1:0]       in_reg,
  output logic [N-1:0]       pend,
  output logic [N-1:0]       ovf,
  output logic               evt_valid,
  output logic [IDW-1:0]     evt_id
`ifdef EDGE_ARB_STAMP_EN
  ,
  output logic [STAMP_W-1:0] evt_stamp
`endif
);

  arb_state_t     state;
  logic [IDW-1:0] last_grant;
  logic [N-1:0]   accept_vec;
  logic [N-1:0]   req;
  logic [IDW-1:0] base;
  logic [IDW-1:0] pick;
  logic           load;

  // First requesting channel after 'last', wrapping modulo N. Every channel is
  // reached within N steps, which is what rules out starvation.
  function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] r,
                                             input logic [IDW-1:0] last);
    logic [IDW-1:0] sel;
    logic           found;
    int             idx;
    sel   = last;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && r[idx]) begin
        sel   = IDW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

`ifdef EDGE_ARB_STAMP_EN
  logic [STAMP_W-1:0] stamp_cnt;
  logic [STAMP_W-1:0] ch_stamp [N];

  always_ff @(posedge clk) begin
    if (!n_rst) stamp_cnt <= '0;
    else        stamp_cnt <= stamp_cnt + 1'b1;
  end
`endif

  for (genvar i = 0; i < N; i++) begin : g_ch
    assign accept_vec[i] = evt_valid & evt_ready & (evt_id == IDW'(i));

    edge_det_ch
`ifdef EDGE_ARB_STAMP_EN
      #(.STAMP_W(STAMP_W))
`endif
      u_ch (
      .clk       (clk),
      .n_rst     (n_rst),
      .in        (in[i]),
      .mode      (mode[2*i+1:2*i]),
      .accept    (accept_vec[i]),
      .ovf_clr   (ovf_clr[i]),
`ifdef EDGE_ARB_STAMP_EN
      .stamp_now (stamp_cnt),
      .stamp     (ch_stamp[i]),
`endif
      .in_reg    (in_reg[i]),
      .pend      (pend[i]),
      .ovf       (ovf[i])
    );
  end

  // While presenting, re-arbitration on accept excludes the channel being
  // drained and starts the search right after it, so the next winner can be
  // loaded on the same edge.
  always_comb begin
    req  = pend;
    base = last_grant;
    if (state == ST_PRESENT) begin
      req  = pend & ~accept_vec;
      base = evt_id;
    end
    pick = rr_pick(req, base);
    load = (state == ST_IDLE) ? (|pend) : (evt_ready && (|req));
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= ST_IDLE;
      evt_valid  <= 1'b0;
      evt_id     <= '0;
      last_grant <= IDW'(N-1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            evt_id    <= pick;
            evt_valid <= 1'b1;
            state     <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          // Held stable until accepted: no withdrawal, no re-arbitration.
          if (evt_ready) begin
            last_grant <= evt_id;
            if (load) begin
              evt_id <= pick;
            end else begin
              evt_valid <= 1'b0;
              state     <= ST_IDLE;
            end
          end
        end
        default: begin
          evt_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef EDGE_ARB_STAMP_EN
  // Loaded together with evt_id so the stamp always belongs to the presented id.
  always_ff @(posedge clk) begin
    if (!n_rst)    evt_stamp <= '0;
    else if (load) evt_stamp <= ch_stamp[pick];
  end
`endif

endmodule

// File: tb/tb_edge_evt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_edge_evt_arbiter
//   Scoreboard bench for edge_evt_arbiter. A cycle-level reference model built
//   from the channel/serving rules pushes each event it expects to be
//   presented into a queue; a monitor pops it when the DUT hands the event
//   over and compares id (and stamp when EDGE_ARB_STAMP_EN is defined). The
//   monitor also compares in_reg/pend/ovf/evt_valid against the model every
//   cycle. Directed scenarios come first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_edge_evt_arbiter;

  localparam int N       = 4;
  localparam int STAMP_W = 4;
  localparam int IDW     = $clog2(N);

  logic               clk     = 1'b0;
  logic               n_rst   = 1'b0;
  logic [N-1:0]       in_v    = '0;
  logic [2*N-1:0]     mode    = '0;
  logic [N-1:0]       ovf_clr = '0;
  logic               evt_ready = 1'b0;
  logic [N-1:0]       in_reg;
  logic [N-1:0]       pend;
  logic [N-1:0]       ovf;
  logic               evt_valid;
  logic [IDW-1:0]     evt_id;
`ifdef EDGE_ARB_STAMP_EN
  logic [STAMP_W-1:0] evt_stamp;
`endif

  int n_vec = 0;
  int n_bad = 0;

  edge_evt_arbiter #(.N(N), .STAMP_W(STAMP_W)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in        (in_v),
    .mode      (mode),
    .ovf_clr   (ovf_clr),
    .evt_ready (evt_ready),
    .in_reg    (in_reg),
    .pend      (pend),
    .ovf       (ovf),
    .evt_valid (evt_valid),
    .evt_id    (evt_id)
`ifdef EDGE_ARB_STAMP_EN
    ,
    .evt_stamp (evt_stamp)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: per-channel flags as plain arrays, events as a queue.
  // ---------------------------------------------------------------------------
  typedef struct {
    int id;
    int stamp;
  } ev_t;

  ev_t exp_q[$];
  bit  m_in   [N];
  bit  m_pend [N];
  bit  m_ovf  [N];
  int  m_stamp[N];
  bit  m_valid = 1'b0;
  int  m_id    = 0;
  int  m_last  = N-1;
  int  m_cnt   = 0;

  // Round-robin: first requester strictly after 'last', wrapping; -1 if none.
  function automatic int model_pick(input bit r[N], input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] to_vec(input bit a[N]);
    logic [N-1:0] v;
    for (int c = 0; c < N; c++) v[c] = a[c];
    return v;
  endfunction

  always @(posedge clk) begin : model
    bit old_pend[N];
    bit r[N];
    bit acc;
    int acc_id;
    int p;
    int md;
    bit rise;
    bit fall;
    bit det;
    if (!n_rst) begin
      for (int c = 0; c < N; c++) begin
        m_in[c] = 0; m_pend[c] = 0; m_ovf[c] = 0; m_stamp[c] = 0;
      end
      m_valid = 0; m_id = 0; m_last = N-1; m_cnt = 0;
      exp_q.delete();
    end else begin
      acc      = m_valid && evt_ready;
      acc_id   = m_id;
      old_pend = m_pend;
      // Serving side works from the flags as they stood before this edge.
      if (!m_valid) begin
        p = model_pick(old_pend, m_last);
        if (p >= 0) begin
          m_valid = 1; m_id = p;
          exp_q.push_back('{id: p, stamp: m_stamp[p]});
        end
      end else if (acc) begin
        m_last = acc_id;
        r = old_pend;
        r[acc_id] = 0;
        p = model_pick(r, m_last);
        if (p >= 0) begin
          m_id = p;
          exp_q.push_back('{id: p, stamp: m_stamp[p]});
        end else begin
          m_valid = 0;
        end
      end
      // Channel side.
      for (int c = 0; c < N; c++) begin
        md   = int'(mode[2*c +: 2]);
        rise = in_v[c] && !m_in[c];
        fall = !in_v[c] && m_in[c];
        det  = (md == 1 && rise) || (md == 2 && fall) || (md == 3 && (rise || fall));
        if (det && (!old_pend[c] || (acc && acc_id == c))) m_stamp[c] = m_cnt;
        if (det && old_pend[c] && !(acc && acc_id == c)) m_ovf[c] = 1;
        else if (ovf_clr[c])                             m_ovf[c] = 0;
        if (det)                       m_pend[c] = 1;
        else if (acc && acc_id == c)   m_pend[c] = 0;
        m_in[c] = in_v[c];
      end
      m_cnt = (m_cnt + 1) % (1 << STAMP_W);
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: compares state every cycle, pops an expected event on handover.
  // ---------------------------------------------------------------------------
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      #1;
      check("in_reg",    32'(in_reg),    32'(to_vec(m_in)));
      check("pend",      32'(pend),      32'(to_vec(m_pend)));
      check("ovf",       32'(ovf),       32'(to_vec(m_ovf)));
      check("evt_valid", 32'(evt_valid), 32'(m_valid));
      if (evt_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL evt_unexpected: got id %0d expected no event at %0t", evt_id, $time);
        end else begin
          e = exp_q[0];
          check("evt_id", 32'(evt_id), 32'(e.id));
`ifdef EDGE_ARB_STAMP_EN
          check("evt_stamp", 32'(evt_stamp), 32'(e.stamp));
`endif
          if (evt_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick(input logic [N-1:0] i, input logic r, input logic [N-1:0] c);
    @(negedge clk);
    in_v      = i;
    evt_ready = r;
    ovf_clr   = c;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] rnd;

    // Reset with all channels on rising edge.
    n_rst = 1'b0; in_v = '0; mode = 8'h55; ovf_clr = '0; evt_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_reg", 32'(in_reg), 32'h0);
    check("rst_pend",   32'(pend),   32'h0);
    check("rst_ovf",    32'(ovf),    32'h0);
    check("rst_valid",  32'(evt_valid), 32'h0);
    n_rst = 1'b1;

    // Single rise on ch2: pend one edge later, event the edge after.
    tick(4'b0100, 1'b0, '0);
    tick(4'b0100, 1'b0, '0); #1;
    check("a_pend",  32'(pend),      32'h4);
    check("a_valid", 32'(evt_valid), 32'h0);
    tick(4'b0100, 1'b1, '0); #1;
    check("a_valid1", 32'(evt_valid), 32'h1);
    check("a_id",     32'(evt_id),    32'h2);
    tick(4'b0100, 1'b0, '0); #1;
    check("a_pend0",  32'(pend),      32'h0);
    check("a_idle",   32'(evt_valid), 32'h0);

    // Fresh reset (last_grant = 3), three rises at once, ready held high.
    @(negedge clk); n_rst = 1'b0; in_v = '0; evt_ready = 1'b0;
    @(negedge clk); n_rst = 1'b1;
    tick(4'b1011, 1'b1, '0);
    tick(4'b1011, 1'b1, '0); #1;
    check("b_pend",  32'(pend),      32'hB);
    check("b_valid", 32'(evt_valid), 32'h0);
    tick(4'b1011, 1'b1, '0); #1;
    check("b_id0", 32'(evt_id), 32'h0);
    tick(4'b1011, 1'b1, '0); #1;
    check("b_id1", 32'(evt_id), 32'h1);
    tick(4'b1011, 1'b1, '0); #1;
    check("b_id3", 32'(evt_id), 32'h3);
    check("b_v3",  32'(evt_valid), 32'h1);
    tick(4'b1011, 1'b0, '0); #1;
    check("b_idle", 32'(evt_valid), 32'h0);

    // Ch0 held while ready=0; ch3 edge only queues behind it.
    tick(4'b1010, 1'b0, '0);
    tick(4'b1011, 1'b0, '0);
    tick(4'b1011, 1'b0, '0);
    tick(4'b0011, 1'b0, '0);
    tick(4'b1011, 1'b0, '0);
    tick(4'b1011, 1'b0, '0);
    tick(4'b1011, 1'b0, '0); #1;
    check("d_id0",  32'(evt_id), 32'h0);
    check("d_pend", 32'(pend),   32'h9);
    tick(4'b1011, 1'b1, '0); #1;
    check("d_hold", 32'(evt_id), 32'h0);
    tick(4'b1011, 1'b0, '0); #1;
    check("d_id3",   32'(evt_id), 32'h3);
    check("d_pend3", 32'(pend),   32'h8);
    tick(4'b1011, 1'b1, '0);
    tick(4'b1011, 1'b0, '0); #1;
    check("d_idle", 32'(evt_valid), 32'h0);

    // Ch1 falling only: its rise is ignored, its fall queues an event.
    mode = 8'h59;
    tick(4'b1001, 1'b1, '0);
    tick(4'b1011, 1'b1, '0);
    tick(4'b1011, 1'b1, '0);
    tick(4'b1001, 1'b1, '0);
    tick(4'b1001, 1'b1, '0);
    tick(4'b1011, 1'b1, '0);

    // Ch1 both edges: pulse with nothing accepted, overflow beats the clear.
    mode = 8'h5D;
    tick(4'b1011, 1'b0, '0);
    tick(4'b1001, 1'b0, '0);
    tick(4'b1011, 1'b0, 4'b0010);
    tick(4'b1011, 1'b0, '0); #1;
    check("e_ovf",   32'(ovf),       32'h2);
    check("e_valid", 32'(evt_valid), 32'h1);
    check("e_id",    32'(evt_id),    32'h1);

    // Reset in the middle of a handshake drops the event.
    @(negedge clk); n_rst = 1'b0; evt_ready = 1'b1;
    @(negedge clk); #1;
    check("f_valid", 32'(evt_valid), 32'h0);
    check("f_pend",  32'(pend),      32'h0);
    check("f_ovf",   32'(ovf),       32'h0);
    n_rst = 1'b1;

    // Randomized traffic; the model and monitor carry the checking.
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      n_rst = ($urandom_range(0, 399) != 0);
      rnd = $urandom;
      if ($urandom_range(0, 2) == 0) in_v = rnd[N-1:0];
      rnd = $urandom;
      if ($urandom_range(0, 49) == 0) mode = rnd[2*N-1:0];
      rnd = $urandom;
      ovf_clr   = ($urandom_range(0, 7) == 0) ? rnd[N-1:0] : '0;
      evt_ready = ($urandom_range(0, 9) < 7);
    end

    // Drain with quiet inputs.
    @(negedge clk);
    n_rst = 1'b1; ovf_clr = '0; evt_ready = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("drain_queue", 32'(exp_q.size()), 32'h0);
    check("drain_valid", 32'(evt_valid),    32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
